// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the miniRISC execute-stage multiplier slice.
package seq_mult_unit_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_t;

endpackage

// File: rtl/seq_mult_unit_add.sv
// 32-bit ADD block: purely combinational sum with carry-out.
module seq_mult_unit_add
  import seq_mult_unit_pkg::*;
(
  input  logic [WORD_W-1:0] input1,
  input  logic [WORD_W-1:0] input2,
  output logic [WORD_W-1:0] sum,
  output logic              carry_from_sum
);

  assign {carry_from_sum, sum} = {1'b0, input1} + {1'b0, input2};

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative 32x32 unsigned shift-and-add multiplier with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one shift-and-add step per cycle, WIDTH steps
//   DONE  | product valid for one cycle; start here chains the next op
module seq_mult_unit
  import seq_mult_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] add_in2;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             last_step;

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign add_in2   = lo_q[0] ? mcand_q : '0;

  seq_mult_unit_add u_add (
    .input1         (hi_q),
    .input2         (add_in2),
    .sum            (add_sum),
    .carry_from_sum (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The 33-bit {carry,sum} is kept whole, so the 64-bit product is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      mcand_q <= multiplicand;
      hi_q    <= '0;
      lo_q    <= multiplier;
    end else if (state_q == RUN) begin
      cnt_q              <= cnt_q + CNT_W'(1);
      {hi_q, lo_q}       <= {add_carry, add_sum, lo_q[WIDTH-1:1]};
    end
  end

  assign product_hi = hi_q;
  assign product_lo = lo_q;

endmodule
